washer_keypad: RTL and testbench
================================

# washer_keypad

Front-panel key input block for the washing-machine controller: the input-side counterpart of the LED/7-segment display path. Synchronizes and debounces four raw panel buttons. Emits single-cycle command pulses, with short/long discrimination on the power key, to the main state machine. Produces the stretched `click` acknowledge that the display block drives onto the buzzer LED.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable samples required to accept a level change.
- `CLICK_CYCLES`, default 100000: length of the `click` acknowledge.
- `LONG_CYCLES`, default 2000000: power-key hold time that counts as a long press.

Ports:
- `cp` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `keyPower`, `keyStart`, `keyMode`, `keyLevel` input 1 each: raw, asynchronous, active-high buttons.
- `powerPulse` output 1: power short press, 1 cycle.
- `powerLong` output 1: power long press, 1 cycle.
- `startPulse` output 1: start/pause press, 1 cycle.
- `modePulse` output 1: mode press, 1 cycle.
- `levelPulse` output 1: water-level press, 1 cycle.
- `click` output 1: high for `CLICK_CYCLES` after any accepted press.
- `busy` output 1: a key is currently accepted and held.

## Operation
- Each key has its own 2-flop synchronizer followed by a debouncer.
- Debouncer:
  - The counter resets whenever the synchronized level equals the debounced level.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES-1`, the debounced level flips and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` are invisible.
- Acceptance FSM states: `IDLE`, `HELD`, `PWR_HELD`, `PWR_LONG`.
- `IDLE`:
  - On a debounced rising edge, accept exactly one key.
  - Simultaneous-edge priority is power > start > mode > level; lower-priority edges that cycle are discarded.
  - Start, mode or level: emit its pulse, go to `HELD`.
  - Power: clear the hold counter, go to `PWR_HELD`, no pulse yet.
- `HELD`: wait until all four debounced levels are low, then return to `IDLE`. New edges during `HELD` are ignored, with no pulse and no click.
- `PWR_HELD`:
  - The hold counter increments every cycle.
  - Power released before the counter reaches `LONG_CYCLES-1`: emit `powerPulse`, go to `HELD` (other keys may still be down).
  - Counter reaches `LONG_CYCLES-1`: emit `powerLong`, go to `PWR_LONG`.
- `PWR_LONG`: no further pulses; go to `HELD` on power release.
- `click`:
  - Loads `CLICK_CYCLES` on every accepted press event: the start/mode/level pulse cycle, or entry into `PWR_HELD`.
  - Stays high while the counter is nonzero.
  - A retrigger reloads the counter and extends `click` without a gap.
- `busy` = state ≠ `IDLE`.

## Timing
- Reset:
  - All outputs 0.
  - Debounced levels 0, all counters 0, FSM in `IDLE`.
  - Synchronizer flops 0.
  - A key held through reset release must pass full debounce before acceptance.
- Press latency: a raw rise stable from cycle 0 gives a debounced rise at cycle `2+DEBOUNCE_CYCLES`. The pulse (start/mode/level) and `click` rise register one cycle later.
- `powerPulse` asserts one cycle after the debounced power fall.
- `powerLong` asserts one cycle after the counter hits the threshold.
- All pulses are exactly one cycle wide. At most one pulse output is high in any cycle.
- `click` is high for exactly `CLICK_CYCLES` cycles after its last trigger.
- Reset mid-press: immediately returns to reset values with no pulse. The held key must debounce again as a new press.
- Counter widths are `$clog2` of their parameters. Counters saturate and never wrap.

## Structure
- Shared package `washer_pkg`:
  - FSM state encoding.
  - Key-index constants (POWER=0, START=1, MODE=2, LEVEL=3).
  - Default parameter values.
- One sub-module, `key_debounce` (synchronizer + debouncer, parameter `DEBOUNCE_CYCLES`), instantiated four times. The FSM and click stretcher live in the top.

## Test plan
Use DEBOUNCE_CYCLES=4, CLICK_CYCLES=8, LONG_CYCLES=20.
1. `keyStart` high for 30 cycles -> `startPulse` single cycle at cycle 7; `click` high cycles 7–14; no other pulse.
2. `keyMode` toggled every 2 cycles for 20 cycles, then low -> no pulse, `click` stays 0.
3. `keyPower` held 10 cycles after acceptance, then released -> `powerPulse` once after the debounced fall; `powerLong` never.
4. `keyPower` held 40 cycles -> `powerLong` once, 20 cycles after acceptance; no `powerPulse` on release.
5. `keyStart` and `keyLevel` rise in the same cycle -> only `startPulse`. `keyMode` pressed during the hold -> ignored. After all keys are released, a fresh `keyMode` press -> `modePulse`.
6. `reset` asserted mid-hold of `keyPower` -> all outputs 0 next cycle; continued hold after reset release yields acceptance only after full debounce.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared definitions for the washer front-panel key path: FSM states, key indices, defaults.
package washer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    PWR_HELD = 2'd2,
    PWR_LONG = 2'd3
  } state_e;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_POWER = 0;
  localparam int KEY_START = 1;
  localparam int KEY_MODE  = 2;
  localparam int KEY_LEVEL = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 20000;
  localparam int DEF_CLICK_CYCLES    = 100000;
  localparam int DEF_LONG_CYCLES     = 2000000;

  // Isolates the lowest set bit, which is the highest-priority key.
  function automatic logic [NUM_KEYS-1:0] lowest_one(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

endpackage

// File: rtl/washer_keypad_if.sv
// Panel buttons in, command pulses and acknowledge out.
interface washer_keypad_if;
  logic keyPower;
  logic keyStart;
  logic keyMode;
  logic keyLevel;
  logic powerPulse;
  logic powerLong;
  logic startPulse;
  logic modePulse;
  logic levelPulse;
  logic click;
  logic busy;

  modport master (
    output keyPower, keyStart, keyMode, keyLevel,
    input  powerPulse, powerLong, startPulse, modePulse, levelPulse, click, busy
  );

  modport slave (
    input  keyPower, keyStart, keyMode, keyLevel,
    output powerPulse, powerLong, startPulse, modePulse, levelPulse, click, busy
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer for one raw button.
// Level flips after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module key_debounce
  import washer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic cp,
  input  logic reset,
  input  logic key_raw,
  output logic key_deb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], key_raw};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign key_deb = deb_q;

endmodule

// File: rtl/washer_keypad.sv
// Front-panel key block: debounces four buttons, accepts one press at a time,
// emits single-cycle command pulses (short/long on power) and a stretched click.
module washer_keypad
  import washer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CLICK_CYCLES    = DEF_CLICK_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input logic            cp,
  input logic            reset,
  washer_keypad_if.slave kp
);

  localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int CKW = $clog2(CLICK_CYCLES + 1);

  logic [NUM_KEYS-1:0] key_raw, deb, rise;
  logic [NUM_KEYS-1:0] deb_prev_q, deb_prev_d;
  logic [NUM_KEYS-1:0] key_pulse_q, key_pulse_d;
  logic                long_q, long_d;
  state_e              state_q, state_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CKW-1:0]      click_cnt_q, click_cnt_d;
  logic                click_load;

  assign key_raw[KEY_POWER] = kp.keyPower;
  assign key_raw[KEY_START] = kp.keyStart;
  assign key_raw[KEY_MODE]  = kp.keyMode;
  assign key_raw[KEY_LEVEL] = kp.keyLevel;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .cp      (cp),
      .reset   (reset),
      .key_raw (key_raw[i]),
      .key_deb (deb[i])
    );
  end

  assign rise = deb & ~deb_prev_q;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    key_pulse_d = '0;
    long_d      = 1'b0;
    click_load  = 1'b0;
    deb_prev_d  = deb;
    case (state_q)
      IDLE: begin
        if (rise[KEY_POWER]) begin
          state_d    = PWR_HELD;
          hold_cnt_d = '0;
          click_load = 1'b1;
        end else if (rise != '0) begin
          key_pulse_d = lowest_one(rise);
          state_d     = HELD;
          click_load  = 1'b1;
        end
      end
      HELD: begin
        if (deb == '0) state_d = IDLE;
      end
      PWR_HELD: begin
        // Reaching the threshold wins over a release seen in the same cycle.
        if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          state_d = PWR_LONG;
        end else if (!deb[KEY_POWER]) begin
          key_pulse_d[KEY_POWER] = 1'b1;
          state_d                = HELD;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      PWR_LONG: begin
        if (!deb[KEY_POWER]) state_d = HELD;
      end
      default: state_d = IDLE;
    endcase

    if (click_load) begin
      click_cnt_d = CKW'(CLICK_CYCLES);
    end else if (click_cnt_q != '0) begin
      click_cnt_d = click_cnt_q - 1'b1;
    end else begin
      click_cnt_d = click_cnt_q;
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      click_cnt_q <= '0;
      key_pulse_q <= '0;
      long_q      <= 1'b0;
      deb_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      click_cnt_q <= click_cnt_d;
      key_pulse_q <= key_pulse_d;
      long_q      <= long_d;
      deb_prev_q  <= deb_prev_d;
    end
  end

  assign kp.powerPulse = key_pulse_q[KEY_POWER];
  assign kp.powerLong  = long_q;
  assign kp.startPulse = key_pulse_q[KEY_START];
  assign kp.modePulse  = key_pulse_q[KEY_MODE];
  assign kp.levelPulse = key_pulse_q[KEY_LEVEL];
  assign kp.click      = (click_cnt_q != '0);
  assign kp.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_washer_keypad.sv
// Bench for washer_keypad: scenario table, corner-case sequences and a random run
// compared every cycle against an event-level reference model.
module tb_washer_keypad;

  localparam int DEB = 4;
  localparam int CLK = 8;
  localparam int LNG = 20;

  logic cp = 1'b0;
  logic reset = 1'b1;

  washer_keypad_if kp ();

  washer_keypad #(
    .DEBOUNCE_CYCLES (DEB),
    .CLICK_CYCLES    (CLK),
    .LONG_CYCLES     (LNG)
  ) dut (
    .cp    (cp),
    .reset (reset),
    .kp    (kp.slave)
  );

  always #5 cp = ~cp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Output vector bits: 6 powerPulse, 5 powerLong, 4 start, 3 mode, 2 level, 1 click, 0 busy
  int first_t[7];
  int cnt[7];

  // Reference model state
  logic [1:0] m_pipe[4];
  logic       m_deb[4];
  logic       m_debp[4];
  int         m_run[4];
  int         m_mode;   // 0 idle, 1 waiting for release, 2 timing power, 3 power long
  int         m_acc;
  int         m_click;
  int         m_edge;
  logic [6:0] m_out;

  function automatic logic [6:0] dut_out();
    return {kp.powerPulse, kp.powerLong, kp.startPulse, kp.modePulse,
            kp.levelPulse, kp.click, kp.busy};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 7; i++) begin
      first_t[i] = -1;
      cnt[i] = 0;
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] keys);
    logic [6:0] o;
    logic [3:0] rise;
    logic       sample;
    o = '0;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_pipe[k] = 2'b00;
        m_deb[k]  = 1'b0;
        m_debp[k] = 1'b0;
        m_run[k]  = 0;
      end
      m_mode = 0; m_click = 0; m_edge = 0; m_acc = 0;
    end else begin
      m_edge++;
      for (int k = 0; k < 4; k++) rise[k] = m_deb[k] & ~m_debp[k];
      m_click = (m_click > 0) ? m_click - 1 : 0;
      case (m_mode)
        0: begin
          if (rise[0]) begin
            m_mode = 2; m_acc = m_edge; m_click = CLK;
          end else begin
            for (int k = 1; k < 4; k++) begin
              if (rise[k] && m_mode == 0) begin
                o[5-k] = 1'b1; m_mode = 1; m_click = CLK;
              end
            end
          end
        end
        1: if (!(m_deb[0] | m_deb[1] | m_deb[2] | m_deb[3])) m_mode = 0;
        2: begin
          if (m_edge - m_acc == LNG) begin
            o[5] = 1'b1; m_mode = 3;
          end else if (!m_deb[0]) begin
            o[6] = 1'b1; m_mode = 1;
          end
        end
        default: if (!m_deb[0]) m_mode = 1;
      endcase
      // A level is accepted after DEB consecutive disagreeing synchronized samples.
      for (int k = 0; k < 4; k++) begin
        sample    = m_pipe[k][1];
        m_pipe[k] = {m_pipe[k][0], keys[k]};
        m_debp[k] = m_deb[k];
        if (sample != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_deb[k] = ~m_deb[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      o[1] = (m_click > 0);
      o[0] = (m_mode != 0);
    end
    m_out = o;
  endtask

  task automatic tick(input logic rst, input logic [3:0] keys);
    logic [6:0] act;
    @(negedge cp);
    reset       = rst;
    kp.keyPower = keys[0];
    kp.keyStart = keys[1];
    kp.keyMode  = keys[2];
    kp.keyLevel = keys[3];
    @(posedge cp);
    model_edge(rst, keys);
    #1;
    cyc = rst ? 0 : cyc + 1;
    act = dut_out();
    checks++;
    if (act !== m_out) begin
      errors++;
      $display("FAIL model cyc=%0d got=%b exp=%b", cyc, act, m_out);
    end
    for (int i = 0; i < 7; i++) begin
      if (act[i]) begin
        cnt[i]++;
        if (first_t[i] < 0) first_t[i] = cyc;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] keys;
    int         hold;
    bit         toggle;
    int         exp_idx;
    int         exp_t;
    int         exp_click_t;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] kv;
    logic [3:0] rk;
    int         dur[4];

    kp.keyPower = 1'b0;
    kp.keyStart = 1'b0;
    kp.keyMode  = 1'b0;
    kp.keyLevel = 1'b0;

    vecs[0] = '{"start",       4'b0010, 30, 1'b0, 4, 7,  7};
    vecs[1] = '{"mode_glitch", 4'b0100, 20, 1'b1, -1, 0, -1};
    vecs[2] = '{"pwr_short",   4'b0001, 17, 1'b0, 6, 24, 7};
    vecs[3] = '{"pwr_long",    4'b0001, 40, 1'b0, 5, 27, 7};
    vecs[4] = '{"start_level", 4'b1010, 30, 1'b0, 4, 7,  7};
    vecs[5] = '{"mode",        4'b0100, 30, 1'b0, 3, 7,  7};
    vecs[6] = '{"level",       4'b1000, 30, 1'b0, 2, 7,  7};

    // Reset state
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0000);
    chk("reset_outputs", int'(dut_out()), 0);

    foreach (vecs[v]) begin
      tick(1'b1, 4'b0000);
      clear_stats();
      for (int c = 0; c < 70; c++) begin
        if (c < vecs[v].hold)
          kv = (vecs[v].toggle && ((c / 2) % 2 == 1)) ? 4'b0000 : vecs[v].keys;
        else
          kv = 4'b0000;
        tick(1'b0, kv);
      end
      for (int i = 2; i <= 6; i++)
        chk($sformatf("%s_cnt%0d", vecs[v].name, i), cnt[i], (i == vecs[v].exp_idx) ? 1 : 0);
      if (vecs[v].exp_idx >= 0)
        chk($sformatf("%s_time", vecs[v].name), first_t[vecs[v].exp_idx], vecs[v].exp_t);
      if (vecs[v].exp_click_t >= 0) begin
        chk($sformatf("%s_click_t", vecs[v].name), first_t[1], vecs[v].exp_click_t);
        chk($sformatf("%s_click_len", vecs[v].name), cnt[1], CLK);
      end else begin
        chk($sformatf("%s_click_len", vecs[v].name), cnt[1], 0);
      end
      chk($sformatf("%s_idle_end", vecs[v].name), int'(kp.busy), 0);
    end

    // Mode pressed during a start hold is ignored; a fresh mode press later is accepted.
    tick(1'b1, 4'b0000);
    clear_stats();
    for (int c = 0; c < 90; c++) begin
      kv = 4'b0000;
      if (c < 40) kv = kv | 4'b1010;
      if (c >= 15 && c < 30) kv = kv | 4'b0100;
      if (c >= 60) kv = kv | 4'b0100;
      tick(1'b0, kv);
    end
    chk("hold_start_cnt", cnt[4], 1);
    chk("hold_level_cnt", cnt[2], 0);
    chk("hold_mode_cnt", cnt[3], 1);
    chk("hold_mode_time", first_t[3], 67);
    chk("hold_click_len", cnt[1], 2 * CLK);

    // Click retrigger while still high extends it without a gap.
    tick(1'b1, 4'b0000);
    clear_stats();
    for (int c = 0; c < 40; c++) begin
      kv = 4'b0000;
      if (c < 6) kv = 4'b0010;
      if (c >= 8 && c < 20) kv = 4'b0100;
      tick(1'b0, kv);
    end
    chk("retrig_mode_time", first_t[3], 15);
    chk("retrig_click_t", first_t[1], 7);
    chk("retrig_click_len", cnt[1], 2 * CLK);

    // Reset in the middle of a power hold.
    tick(1'b1, 4'b0000);
    for (int c = 0; c < 12; c++) tick(1'b0, 4'b0001);
    chk("pre_rst_busy", int'(kp.busy), 1);
    tick(1'b1, 4'b0001);
    chk("mid_rst_outputs", int'(dut_out()), 0);
    clear_stats();
    for (int c = 0; c < 20; c++) tick(1'b0, 4'b0001);
    chk("post_rst_accept", first_t[0], 7);
    chk("post_rst_click", first_t[1], 7);
    chk("post_rst_pulses", cnt[2] + cnt[3] + cnt[4] + cnt[5] + cnt[6], 0);
    for (int c = 0; c < 20; c++) tick(1'b0, 4'b0000);

    // Random key activity with occasional reset, checked against the model each cycle.
    rk = 4'b0000;
    for (int k = 0; k < 4; k++) dur[k] = $urandom_range(5, 40);
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (dur[k] == 0) begin
          rk[k] = ~rk[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
        end else begin
          dur[k]--;
        end
      end
      tick(($urandom_range(0, 299) == 0), rk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
